shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Control sequencer for an N-bit universal shift register built from bitHolder cells, which share modo, dir and clkenb = clk & enb.
- Accepts one operation per start pulse and runs it to completion: a parallel load, followed optionally by K serial shifts or rotations in one direction.
- Drives every register control line and reports busy/done to the host.

Parameters:
- N, 4, register width (number of bitHolder cells).
- CNTW, 3, width of the shift/rotate count field.

Ports:
- clk  in  1  system clock; the register is clocked by clk & enb.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  operation request, sampled on posedge clk.
- op_modo  in  2  00 serial shift, 01 rotate, 1x parallel load only.
- op_dir  in  1  0 left, 1 right.
- op_cnt  in  CNTW  number of shift/rotate steps (0..2^CNTW-1).
- d_in  in  N  word to load.
- s_serial  in  1  fill bit for serial shift.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- modo  out  2  to all cells.
- dir  out  1  to all cells.
- d_n  out  N  parallel data to the cells.
- s_fill  out  1  serial input at the register end selected by dir.
- enb  out  1  clock enable, ANDed with clk externally.

Behaviour:
- One clock domain. Reset is asynchronous, active-high, and applies to every flop on both edges.
- FSM states: IDLE, LOAD, SHIFT, DONE. The FSM, counter and operation capture registers update on posedge clk.
- IDLE: start=1 at posedge t0 captures op_modo, op_dir, op_cnt, d_in, s_serial and moves to LOAD. start is ignored in all other states.
- LOAD: the register loads at posedge t1.
  - If op_modo[1]=1 or op_cnt=0, go to DONE.
  - Otherwise go to SHIFT with rem=op_cnt.
- SHIFT: each posedge is one register step and decrements rem. At the edge where rem=1, go to DONE. Shifts occur at t2..t(cnt+1).
- DONE: done=1 for exactly one cycle, then IDLE. done is high from t(cnt+1) to t(cnt+2); for load-only or cnt=0, from t1 to t2.
- busy=1 in LOAD, SHIFT and DONE. busy and done are posedge-registered.
- Control outputs (modo, dir, d_n, s_fill, enb) are registered on negedge clk from the current state. They are therefore stable while clk is high, so clk & enb never produces a runt or extra edge. Per state:
  - LOAD: enb=1, modo=10, d_n=captured d_in.
  - SHIFT: enb=1, modo=captured op_modo, dir=captured op_dir, s_fill=captured s_serial.
  - IDLE/DONE: enb=0; modo, dir, d_n and s_fill hold their last values.
- enb is high for exactly 1+cnt rising clk edges per operation (1 for load-only).
- Reset values: state=IDLE, rem=0, busy=0, done=0, enb=0, modo=00, dir=0, d_n=0, s_fill=0.
- Reset mid-operation: enb drops immediately and asynchronously, so no further register edge occurs. Register contents are left as they were.
- start held high continuously: a new operation is accepted only in IDLE, one cycle after DONE.
- op_cnt is not range-checked: a full 2^CNTW-1 count is legal; a rotate count ≥ N simply wraps.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN. When defined, adds input abort (1) and output aborted (1).
- abort=1 at a posedge in SHIFT:
  - That edge still shifts, since enb was already high.
  - FSM goes to DONE; enb=0 from the following negedge.
  - aborted=1 together with done, as a one-cycle pulse.
- abort is ignored outside SHIFT.
- When the macro is undefined, neither port exists and the behaviour is exactly as above.

Test Plan:
- Load only (N=4): op_modo=10, d_in=1011, start 1 cycle -> enb high for 1 edge; register=1011; done pulses at t1; busy=0 from t2.
- Rotate left: op_modo=01, op_dir=0, op_cnt=1, d_in=1011 -> register=0111; exactly 2 enabled edges; done at t2.
- Serial right: op_modo=00, op_dir=1, op_cnt=3, s_serial=1, d_in=0000 -> 1000, 1100, 1110 on successive edges; done at t4.
- op_cnt=0 with op_modo=00 and d_in=0101 -> load only; register=0101; done at t1. start asserted during busy -> ignored; no second done.
- rst pulsed mid-SHIFT of a 5-step rotate -> enb=0 within the reset pulse; busy=0, done=0; register frozen at the partially rotated value. A start after reset runs normally.
- SHIFT_SEQ_ABORT_EN defined: 6-step rotate of 0001, abort at second shift edge -> register=0100; done=aborted=1 for one cycle; no further enabled edges.

Source files
------------

// File: rtl/shift_sequencer.sv
// Sequencer for an N-bit universal shift register built from bitHolder cells.
// Optional abort input/aborted output: define SHIFT_SEQ_ABORT_EN.
module shift_sequencer #(
   parameter int N    = 4,
   parameter int CNTW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op_modo,
   input  logic            op_dir,
   input  logic [CNTW-1:0] op_cnt,
   input  logic [N-1:0]    d_in,
   input  logic            s_serial,
`ifdef SHIFT_SEQ_ABORT_EN
   input  logic            abort,
   output logic            aborted,
`endif
   output logic            busy,
   output logic            done,
   output logic [1:0]      modo,
   output logic            dir,
   output logic [N-1:0]    d_n,
   output logic            s_fill,
   output logic            enb
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] rem_q, rem_d;
   logic [1:0]      modo_cap_q, modo_cap_d;
   logic            dir_cap_q, dir_cap_d;
   logic [CNTW-1:0] cnt_cap_q, cnt_cap_d;
   logic [N-1:0]    d_cap_q, d_cap_d;
   logic            s_cap_q, s_cap_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            aborted_q, aborted_d;
   logic            abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
   assign abort_req = abort;
   assign aborted   = aborted_q;
`else
   assign abort_req = 1'b0;
`endif

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      modo_cap_d = modo_cap_q;
      dir_cap_d  = dir_cap_q;
      cnt_cap_d  = cnt_cap_q;
      d_cap_d    = d_cap_q;
      s_cap_d    = s_cap_q;
      aborted_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               modo_cap_d = op_modo;
               dir_cap_d  = op_dir;
               cnt_cap_d  = op_cnt;
               d_cap_d    = d_in;
               s_cap_d    = s_serial;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (modo_cap_q[1] || cnt_cap_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
               rem_d   = cnt_cap_q;
            end
         end
         ST_SHIFT: begin
            rem_d = rem_q - 1'b1;
            if (rem_q <= 1 || abort_req) begin
               state_d   = ST_DONE;
               aborted_d = abort_req && rem_q > 1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         modo_cap_q <= '0;
         dir_cap_q  <= 1'b0;
         cnt_cap_q  <= '0;
         d_cap_q    <= '0;
         s_cap_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         modo_cap_q <= modo_cap_d;
         dir_cap_q  <= dir_cap_d;
         cnt_cap_q  <= cnt_cap_d;
         d_cap_q    <= d_cap_d;
         s_cap_q    <= s_cap_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
      end
   end

   // NOTE: controls change on the falling edge so clk & enb never glitches; rst still clears enb at once.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         enb    <= 1'b0;
         modo   <= 2'b00;
         dir    <= 1'b0;
         d_n    <= '0;
         s_fill <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               enb  <= 1'b1;
               modo <= 2'b10;
               d_n  <= d_cap_q;
            end
            ST_SHIFT: begin
               enb    <= 1'b1;
               modo   <= modo_cap_q;
               dir    <= dir_cap_q;
               s_fill <= s_cap_q;
            end
            default: enb <= 1'b0;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the bitHolder register.
// Abort scenario is exercised only when SHIFT_SEQ_ABORT_EN is defined.
module tb_shift_sequencer;
   localparam int N    = 4;
   localparam int CNTW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [1:0]      op_modo = 2'b00;
   logic            op_dir = 1'b0;
   logic [CNTW-1:0] op_cnt = '0;
   logic [N-1:0]    d_in = '0;
   logic            s_serial = 1'b0;
   logic            busy, done, dir, s_fill, enb;
   logic [1:0]      modo;
   logic [N-1:0]    d_n;
`ifdef SHIFT_SEQ_ABORT_EN
   logic            abort = 1'b0;
   logic            aborted;
`endif

   int           n_checks = 0;
   int           n_errors = 0;
   int           en_edges = 0;
   logic [N-1:0] sreg = '0;
   logic [N-1:0] hist [0:40];
   int           e0;

   shift_sequencer #(.N(N), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .start(start), .op_modo(op_modo), .op_dir(op_dir),
      .op_cnt(op_cnt), .d_in(d_in), .s_serial(s_serial),
`ifdef SHIFT_SEQ_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .busy(busy), .done(done), .modo(modo), .dir(dir), .d_n(d_n),
      .s_fill(s_fill), .enb(enb)
   );

   always #5 clk = ~clk;

   wire gclk = clk & enb;

   // Register plant: every cell shares modo/dir and is clocked by clk & enb.
   always @(posedge gclk) begin
      case (modo)
         2'b00:   sreg <= dir ? {s_fill, sreg[N-1:1]} : {sreg[N-2:0], s_fill};
         2'b01:   sreg <= dir ? {sreg[0], sreg[N-1:1]} : {sreg[N-2:0], sreg[N-1]};
         default: sreg <= d_n;
      endcase
   end

   always @(posedge clk) if (enb === 1'b1) en_edges <= en_edges + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] m, input logic dr,
                         input logic [CNTW-1:0] c, input logic [N-1:0] d, input logic s,
                         input bit hold, input int abort_at, input int exp_lat,
                         input logic [N-1:0] exp_reg, input int exp_edges, input bit exp_abort);
      int  k;
      bit  seen;
      bit  ab_seen;
      @(posedge clk); #1;
      op_modo = m; op_dir = dr; op_cnt = c; d_in = d; s_serial = s; start = 1'b1;
      e0 = en_edges;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      check({tag, " busy_t0"}, {31'd0, busy}, 32'd1);
      seen = 1'b0; ab_seen = 1'b0; k = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
`ifdef SHIFT_SEQ_ABORT_EN
         if (i == abort_at) abort = 1'b1;
`endif
         @(posedge clk); #1;
`ifdef SHIFT_SEQ_ABORT_EN
         abort = 1'b0;
         if (aborted === 1'b1) ab_seen = 1'b1;
`endif
         hist[i] = sreg;
         if (done === 1'b1) begin
            seen = 1'b1;
            k = i;
         end
      end
      start = 1'b0;
      check({tag, " done_lat"}, k, exp_lat);
      check({tag, " reg"}, {28'd0, sreg}, {28'd0, exp_reg});
`ifdef SHIFT_SEQ_ABORT_EN
      check({tag, " aborted"}, {31'd0, ab_seen}, {31'd0, exp_abort});
`else
      if (exp_abort) check({tag, " abort_unsupported"}, 32'd0, 32'd1);
`endif
      @(posedge clk); #1;
      check({tag, " done_off"}, {31'd0, done}, 32'd0);
      check({tag, " busy_off"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check({tag, " en_edges"}, en_edges - e0, exp_edges);
   endtask

   initial begin
      #3;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst enb", {31'd0, enb}, 32'd0);
      check("rst ctrl", {25'd0, modo, dir, d_n, s_fill}, 32'd0);
      #9 rst = 1'b0;

      // Load only; cnt is ignored when op_modo[1]=1.
      run_op("load", 2'b10, 1'b0, 3'd3, 4'b1011, 1'b0, 0, 0, 1, 4'b1011, 1, 0);
      check("load d_n", {28'd0, d_n}, 32'hb);
      check("load modo", {30'd0, modo}, 32'h2);

      run_op("rotl", 2'b01, 1'b0, 3'd1, 4'b1011, 1'b0, 0, 0, 2, 4'b0111, 2, 0);

      run_op("serr", 2'b00, 1'b1, 3'd3, 4'b0000, 1'b1, 0, 0, 4, 4'b1110, 4, 0);
      check("serr step1", {28'd0, hist[2]}, 32'h8);
      check("serr step2", {28'd0, hist[3]}, 32'hc);
      check("serr step3", {28'd0, hist[4]}, 32'he);
      check("serr hold ctrl", {29'd0, modo, dir}, 32'h1);

      // Zero count with start held through the busy window.
      run_op("cnt0", 2'b00, 1'b0, 3'd0, 4'b0101, 1'b0, 1, 0, 1, 4'b0101, 1, 0);
      begin
         bit extra = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
         end
         check("cnt0 no_second_op", {31'd0, extra}, 32'd0);
      end

      // Reset in the middle of a 5-step left rotate of 1011.
      @(posedge clk); #1;
      op_modo = 2'b01; op_dir = 1'b0; op_cnt = 3'd5; d_in = 4'b1011; start = 1'b1;
      e0 = en_edges;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst enb", {31'd0, enb}, 32'd0);
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst reg", {28'd0, sreg}, 32'he);
      check("midrst edges", en_edges - e0, 3);

      run_op("after_rst", 2'b01, 1'b1, 3'd2, 4'b0110, 1'b0, 0, 0, 3, 4'b1001, 3, 0);

`ifdef SHIFT_SEQ_ABORT_EN
      run_op("abort", 2'b01, 1'b0, 3'd6, 4'b0001, 1'b0, 0, 3, 3, 4'b0100, 3, 1);
`endif

      // Full-range count: 7 right rotates of 1000 wrap to 0001.
      run_op("cnt7", 2'b01, 1'b1, 3'd7, 4'b1000, 1'b0, 0, 0, 8, 4'b0001, 8, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
